// File: rtl/seq_divider.sv
// Iterative restoring divider (signed/unsigned) with valid/ready handshakes and tag pass-through.
// Optional macro SEQ_DIVIDER_FAST_ZERO_EN: skip iteration for b==0, a==0 and signed MIN/-1.
module seq_divider #(
  parameter int DATA_LEN       = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_LEN        = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] a,
  input  logic [DATA_LEN-1:0] b,
  input  logic                is_signed,
  input  logic [TAG_LEN-1:0]  in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] quotient,
  output logic [DATA_LEN-1:0] remainder,
  output logic                div_zero,
  output logic                overflow,
  output logic [TAG_LEN-1:0]  out_tag
);

  localparam int L  = DATA_LEN / BITS_PER_CYCLE;
  localparam int PW = DATA_LEN + BITS_PER_CYCLE;
  localparam int CW = $clog2(L + 1);
  localparam logic [DATA_LEN-1:0] MIN_VAL = {1'b1, {(DATA_LEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t               r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [DATA_LEN-1:0]  r_dvd;
  logic [DATA_LEN-1:0]  r_dvs;
  logic [DATA_LEN-1:0]  r_a;
  logic [PW-1:0]        r_prem;
  logic [CW-1:0]        r_cnt;
  logic                 r_sign_q;
  logic                 r_sign_r;
  logic                 r_zero;
  logic                 r_ovf;
  logic [TAG_LEN-1:0]   r_tag;
  logic [DATA_LEN-1:0]  r_quotient;
  logic [DATA_LEN-1:0]  r_remainder;
  logic                 r_div_zero;
  logic                 r_overflow;
  logic [TAG_LEN-1:0]   r_out_tag;

  logic [DATA_LEN-1:0]  w_abs_a;
  logic [DATA_LEN-1:0]  w_abs_b;
  logic                 w_ovf;
  logic                 w_accept;
  logic [PW-1:0]        w_rem;
  logic [DATA_LEN-1:0]  w_quo;
  logic [DATA_LEN-1:0]  w_mag_r;
  logic [DATA_LEN-1:0]  w_q_fin;
  logic [DATA_LEN-1:0]  w_r_fin;
  logic [CW-1:0]        w_cnt_start;

  assign w_accept = in_valid && r_in_ready;
  // MIN's magnitude 2^(DATA_LEN-1) fits DATA_LEN unsigned bits, so plain negation suffices.
  assign w_abs_a  = (is_signed && a[DATA_LEN-1]) ? -a : a;
  assign w_abs_b  = (is_signed && b[DATA_LEN-1]) ? -b : b;
  assign w_ovf    = is_signed && (a == MIN_VAL) && (b == '1);

`ifdef SEQ_DIVIDER_FAST_ZERO_EN
  logic w_fast;
  assign w_fast      = (b == '0) || (a == '0) || w_ovf;
  assign w_cnt_start = w_fast ? CW'(L) : '0;
`else
  assign w_cnt_start = '0;
`endif

  // Dividend shifts out of r_dvd MSB-first while quotient bits shift in at the LSB.
  always_comb begin
    w_rem = r_prem;
    w_quo = r_dvd;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      w_rem = {w_rem[PW-2:0], w_quo[DATA_LEN-1]};
      w_quo = {w_quo[DATA_LEN-2:0], 1'b0};
      if (w_rem >= {{BITS_PER_CYCLE{1'b0}}, r_dvs}) begin
        w_rem    = w_rem - {{BITS_PER_CYCLE{1'b0}}, r_dvs};
        w_quo[0] = 1'b1;
      end
    end
  end

  assign w_mag_r = r_prem[DATA_LEN-1:0];

  always_comb begin
    w_q_fin = r_sign_q ? -r_dvd : r_dvd;
    w_r_fin = r_sign_r ? -w_mag_r : w_mag_r;
    if (r_zero) begin
      w_q_fin = '1;
      w_r_fin = r_a;
    end else if (r_ovf) begin
      w_q_fin = MIN_VAL;
      w_r_fin = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_a         <= '0;
      r_prem      <= '0;
      r_cnt       <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_tag       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
      r_overflow  <= 1'b0;
      r_out_tag   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_dvd      <= w_abs_a;
            r_dvs      <= w_abs_b;
            r_a        <= a;
            r_prem     <= '0;
            r_cnt      <= w_cnt_start;
            r_sign_q   <= is_signed && (a[DATA_LEN-1] ^ b[DATA_LEN-1]);
            r_sign_r   <= is_signed && a[DATA_LEN-1];
            r_zero     <= (b == '0);
            r_ovf      <= w_ovf;
            r_tag      <= in_tag;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          if (r_cnt != CW'(L)) begin
            r_prem <= w_rem;
            r_dvd  <= w_quo;
            r_cnt  <= r_cnt + CW'(1);
          end else begin
            r_quotient  <= w_q_fin;
            r_remainder <= w_r_fin;
            r_div_zero  <= r_zero;
            r_overflow  <= r_ovf && !r_zero;
            r_out_tag   <= r_tag;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;
  assign overflow  = r_overflow;
  assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: one instance at 1 bit/cycle, one at 2 bits/cycle, driven in lockstep.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        is_signed = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, div_zero, overflow;
  logic [31:0] quotient, remainder;
  logic [3:0]  out_tag;
  logic        in_ready2, out_valid2, div_zero2, overflow2;
  logic [31:0] quotient2, remainder2;
  logic [3:0]  out_tag2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_divider #(.DATA_LEN(32), .BITS_PER_CYCLE(1), .TAG_LEN(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero), .overflow(overflow), .out_tag(out_tag)
  );

  seq_divider #(.DATA_LEN(32), .BITS_PER_CYCLE(2), .TAG_LEN(4)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .is_signed(is_signed), .in_tag(in_tag),
    .out_valid(out_valid2), .out_ready(out_ready),
    .quotient(quotient2), .remainder(remainder2),
    .div_zero(div_zero2), .overflow(overflow2), .out_tag(out_tag2)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [3:0]  tag;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
    logic        fast;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic fast, input int full);
`ifdef SEQ_DIVIDER_FAST_ZERO_EN
    return fast ? 1 : full;
`else
    return (fast === 1'bx) ? 0 : full;
`endif
  endfunction

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                        input logic [3:0] tt, output int lat, output int lat2);
    @(negedge clk);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = ta; b = tb; is_signed = ts; in_tag = tt; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; in_tag = 4'($urandom);
    lat = 0; lat2 = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid2 && lat2 == 0) lat2 = lat;
    end
    if (lat >= 100) chk("result_timeout", 32'(out_valid), 32'd1);
  endtask

  initial begin : main
    int lat, lat2;
    logic [3:0] tg;

    vecs[0]  = '{32'd100,      32'hFFFFFFF9, 1'b1, 4'h5, 32'hFFFFFFF2, 32'd2,        1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'hFFFFFF9C, 32'd7,        1'b1, 4'h6, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'hFFFFFFFF, 32'd2,        1'b0, 4'h7, 32'h7FFFFFFF, 32'd1,        1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'd5,        32'd0,        1'b1, 4'h8, 32'hFFFFFFFF, 32'd5,        1'b1, 1'b0, 1'b1};
    vecs[4]  = '{32'd5,        32'd0,        1'b0, 4'h9, 32'hFFFFFFFF, 32'd5,        1'b1, 1'b0, 1'b1};
    vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 4'hA, 32'h80000000, 32'd0,        1'b0, 1'b1, 1'b1};
    vecs[6]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 4'hB, 32'd0,        32'h80000000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'd0,        32'd3,        1'b0, 4'hC, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1};
    vecs[8]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 4'hD, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'd1000,     32'd10,       1'b0, 4'hE, 32'd100,      32'd0,        1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'hFFFFFFFB, 32'd0,        1'b1, 4'hF, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{32'h80000000, 32'd2,        1'b1, 4'h1, 32'hC0000000, 32'd0,        1'b0, 1'b0, 1'b0};
    vecs[12] = '{32'h80000000, 32'h80000000, 1'b1, 4'h2, 32'd1,        32'd0,        1'b0, 1'b0, 1'b0};

    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_flags", {30'd0, div_zero, overflow}, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("in_ready_before_first_edge", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("in_ready_after_first_edge", 32'(in_ready), 32'd1);
    chk("in_ready2_after_first_edge", 32'(in_ready2), 32'd1);

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].tag, lat, lat2);
      chk($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
      chk($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
      chk($sformatf("v%0d_div_zero", i), 32'(div_zero), 32'(vecs[i].dz));
      chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].ov));
      chk($sformatf("v%0d_out_tag", i), 32'(out_tag), 32'(vecs[i].tag));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].fast, 33)));
      chk($sformatf("v%0d_latency_bpc2", i), 32'(lat2), 32'(exp_lat(vecs[i].fast, 17)));
      chk($sformatf("v%0d_quotient_bpc2", i), quotient2, vecs[i].q);
      chk($sformatf("v%0d_remainder_bpc2", i), remainder2, vecs[i].r);
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid_cleared", i), 32'(out_valid), 32'd0);
      chk($sformatf("v%0d_in_ready_back", i), 32'(in_ready), 32'd1);
    end

    // Back-pressure: results must hold while the consumer stalls.
    out_ready = 1'b0;
    run_op(32'd100, 32'hFFFFFFF9, 1'b1, 4'h3, lat, lat2);
    chk("bp_latency", 32'(lat), 32'd33);
    chk("bp_latency_bpc2", 32'(lat2), 32'd17);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 32'd9; b = 32'd4; in_tag = 4'h0;
      @(posedge clk); #1;
      chk($sformatf("bp%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_quotient", i), quotient, 32'hFFFFFFF2);
      chk($sformatf("bp%0d_remainder", i), remainder, 32'd2);
      chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp%0d_bpc2_valid", i), 32'(out_valid2), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_in_ready2", 32'(in_ready2), 32'd1);
    repeat (3) @(posedge clk);
    #1 chk("bp_no_stray_accept", 32'(out_valid | in_ready == 1'b0), 32'd0);

    // Reset in the middle of CALC aborts the operation.
    @(negedge clk);
    a = 32'd100; b = 32'd3; is_signed = 1'b0; in_tag = 4'h4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_flags", {30'd0, div_zero, overflow}, 32'd0);
    chk("abort_out_tag", 32'(out_tag), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready_after", 32'(in_ready), 32'd1);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) lat++;
    end
    chk("abort_no_result", 32'(lat), 32'd0);
    tg = 4'h6;
    run_op(32'd7, 32'd2, 1'b0, tg, lat, lat2);
    chk("post_abort_quotient", quotient, 32'd3);
    chk("post_abort_remainder", remainder, 32'd1);
    chk("post_abort_latency", 32'(lat), 32'd33);
    chk("post_abort_tag", 32'(out_tag), 32'(tg));
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Parametrised iterative divider with valid/ready handshakes. It computes quotient and remainder, selectable signed or unsigned per operation. Divide-by-zero and signed-overflow cases are explicitly flagged. It carries an opaque tag so upstream logic can match results to requests. It is the handshaked, back-pressurable successor to the fixed-latency always-valid divider in the datapath.

Parameters:
DATA_LEN, 32, operand/result width in bits
BITS_PER_CYCLE, 1, quotient bits resolved per iteration cycle; legal values 1 or 2; DATA_LEN must be divisible by it
TAG_LEN, 4, width of pass-through request tag (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
a  in  DATA_LEN  dividend
b  in  DATA_LEN  divisor
is_signed  in  1  1 = two's-complement operands, 0 = unsigned
in_tag  in  TAG_LEN  request tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
quotient  out  DATA_LEN  quotient
remainder  out  DATA_LEN  remainder
div_zero  out  1  b was zero
overflow  out  1  signed MIN / -1
out_tag  out  TAG_LEN  tag of this result

Behaviour:
- Reset is asynchronous and active-low; clock is clk.
- While reset is low: state=IDLE, in_ready=0, out_valid=0, and quotient, remainder, div_zero, overflow, out_tag are all 0.
- From the first edge after reset deasserts, in_ready=1.
- State machine: IDLE -> CALC -> DONE -> IDLE. in_ready = (state==IDLE) and reset high. Only one operation is in flight.
- Accept happens on the edge where in_valid && in_ready. On that edge:
  - Latch |a| and |b| (magnitudes when is_signed, else raw).
  - Latch sign_q = a[MSB]^b[MSB] and sign_r = a[MSB] (both 0 when unsigned), plus is_signed and in_tag.
  - Latch zero/overflow detection.
  - Go to CALC.
- CALC: restoring shift-subtract on magnitudes, BITS_PER_CYCLE quotient bits per edge, for L = DATA_LEN/BITS_PER_CYCLE edges. An iteration counter tracks progress.
- After the L-th CALC edge, the next edge applies sign correction, registers all outputs, sets out_valid=1 and enters DONE.
- Latency: out_valid is high L+1 edges after the accept edge (33 for defaults).
- Signed semantics truncate toward zero. The remainder takes the sign of the dividend, so a == quotient*b + remainder (mod 2^DATA_LEN).
- Width rule: the magnitude of MIN (2^(DATA_LEN-1)) is held in DATA_LEN unsigned bits, with no extra sign bit. The partial remainder register is DATA_LEN+BITS_PER_CYCLE bits wide.
- b==0, either mode: quotient = all ones, remainder = a (unmodified), div_zero=1, overflow=0. The iteration result is overridden.
- is_signed && a==MIN && b==-1: quotient = MIN, remainder = 0, overflow=1, div_zero=0.
- DONE: outputs and out_valid are held stable while out_ready=0. On the edge with out_valid && out_ready: out_valid=0, go to IDLE, and in_ready=1 from that edge.
- Outputs keep their last values after the handshake; consumers sample them only when out_valid=1.
- in_valid while in_ready=0 is ignored. Inputs are not sampled outside the accept edge.
- Reset asserted mid-CALC or mid-DONE aborts the operation immediately. No out_valid is produced for it.

Optional Feature:
Macro: SEQ_DIVIDER_FAST_ZERO_EN.
- Defined: when b==0, or a==0, or the MIN/-1 overflow case is detected at accept, CALC is skipped. The result is registered on the next edge (out_valid 1 edge after accept) with the values defined above; a==0 gives quotient=0, remainder=0. Other operations are unchanged.
- Undefined: every operation takes the full L+1 latency, including the special cases.

Test Plan:
- Signed, 100 / -7, defaults: quotient=0xFFFFFFF2 (-14), remainder=2, flags 0, out_valid exactly 33 edges after accept, out_tag = in_tag.
- Signed, -100 / 7: quotient=0xFFFFFFF2, remainder=0xFFFFFFFE (-2). Unsigned, 0xFFFFFFFF / 2: quotient=0x7FFFFFFF, remainder=1.
- 5 / 0, each mode: quotient=0xFFFFFFFF, remainder=5, div_zero=1. With SEQ_DIVIDER_FAST_ZERO_EN: out_valid 1 edge after accept; without it: 33 edges.
- Signed, 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0, overflow=1. The same operands unsigned give quotient=0, remainder=0x80000000, flags 0.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid rises. Outputs stay stable, in_ready stays 0, and in_valid pulses are ignored. Releasing out_ready returns in_ready to 1 on the following edge. Repeat with BITS_PER_CYCLE=2: latency 17.
- Assert reset low at CALC iteration 10: out_valid stays 0, all outputs read 0, and in_ready=1 after release. A new 7 / 2 then completes with quotient=3, remainder=1.
